// File: rtl/ls139_access_sched_if.sv
// Request and decoder-drive signals shared between the bus-master request logic and the
// access scheduler. Both channels use the same bundle.
interface ls139_access_sched_if;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic [1:0] sel_a;
   logic       g1n;
   logic [1:0] sel_b;
   logic       g2n;
   logic [3:0] gnt_a;
   logic [3:0] gnt_b;
   logic       done_a;
   logic       done_b;
   logic       busy_a;
   logic       busy_b;

   modport master (
      output req_a, req_b,
      input  sel_a, g1n, sel_b, g2n, gnt_a, gnt_b, done_a, done_b, busy_a, busy_b
   );

   modport slave (
      input  req_a, req_b,
      output sel_a, g1n, sel_b, g2n, gnt_a, gnt_b, done_a, done_b, busy_a, busy_b
   );
endinterface

// File: rtl/ls139_access_sched.sv
// Dual-channel access scheduler for a '139 decoder: setup, enable hold, release per access.
// LS139_FIXED_PRIORITY_EN selects lowest-index-wins instead of round-robin arbitration.
module ls139_access_sched_chan #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] req,
   output logic [1:0] sel,
   output logic       gn,
   output logic [3:0] gnt,
   output logic       done,
   output logic       busy
);
   localparam int CW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RELEASE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    sel_nx;
   logic [1:0]    win;
   logic          win_vld;
`ifndef LS139_FIXED_PRIORITY_EN
   logic [1:0]    ptr, ptr_nx;
   logic [1:0]    idx;
`endif

   // Scan downward so the candidate closest to the priority origin is the last to overwrite.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
`ifdef LS139_FIXED_PRIORITY_EN
      for (int k = 3; k >= 0; k--) begin
         if (req[k]) begin
            win     = 2'(k);
            win_vld = 1'b1;
         end
      end
`else
      idx = '0;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      cnt_nx   = cnt;
`ifndef LS139_FIXED_PRIORITY_EN
      ptr_nx   = ptr;
`endif
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nx = SETUP;
               sel_nx   = win;
`ifndef LS139_FIXED_PRIORITY_EN
               ptr_nx   = win + 2'd1;
`endif
            end
         end
         SETUP: begin
            state_nx = ACTIVE;
            cnt_nx   = CW'(HOLD_CYCLES);
         end
         ACTIVE: begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1)) state_nx = RELEASE;
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every output comes straight off a flop.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         sel   <= '0;
         cnt   <= '0;
`ifndef LS139_FIXED_PRIORITY_EN
         ptr   <= '0;
`endif
         gn    <= 1'b1;
         gnt   <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         cnt   <= cnt_nx;
`ifndef LS139_FIXED_PRIORITY_EN
         ptr   <= ptr_nx;
`endif
         gn    <= (state_nx != ACTIVE);
         gnt   <= (state_nx == ACTIVE) ? 4'(4'b0001 << sel_nx) : 4'b0000;
         done  <= (state_nx == RELEASE);
         busy  <= (state_nx != IDLE);
      end
   end
endmodule

module ls139_access_sched #(
   parameter int HOLD_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rstn,
   ls139_access_sched_if.slave bus
);
   ls139_access_sched_chan #(.HOLD_CYCLES(HOLD_CYCLES)) u_chan_a (
      .clk  (clk),
      .rstn (rstn),
      .req  (bus.req_a),
      .sel  (bus.sel_a),
      .gn   (bus.g1n),
      .gnt  (bus.gnt_a),
      .done (bus.done_a),
      .busy (bus.busy_a)
   );

   ls139_access_sched_chan #(.HOLD_CYCLES(HOLD_CYCLES)) u_chan_b (
      .clk  (clk),
      .rstn (rstn),
      .req  (bus.req_b),
      .sel  (bus.sel_b),
      .gn   (bus.g2n),
      .gnt  (bus.gnt_b),
      .done (bus.done_b),
      .busy (bus.busy_b)
   );
endmodule

// File: doc/ls139_access_sched.md
# ls139_access_sched

Access scheduler for the dual 2-to-4 chip-select decoder. Two independent channels (A and B) each arbitrate four level-sensitive requesters and drive the decoder select code and active-low enable for the winner. Every access follows a glitch-free sequence: select code settles with the enable off, enable asserts for a fixed hold window, then one dead cycle. Sits between the bus-master request logic and the decoder's A/G1n and B/G2n inputs.

## Interface
- HOLD_CYCLES, 2, cycles the enable is held low per access (legal range 1..255)
- clk  in  1  rising-edge clock, sole clock
- rstn  in  1  reset; one clock, synchronous, active-low
- req_a  in  4  channel A requests, level, bit i = requester i
- req_b  in  4  channel B requests, level
- sel_a  out  2  select code to decoder A input
- g1n  out  1  decoder channel A enable, active low
- sel_b  out  2  select code to decoder B input
- g2n  out  1  decoder channel B enable, active low
- gnt_a  out  4  one-hot grant, high only while g1n is low
- gnt_b  out  4  one-hot grant, high only while g2n is low
- done_a  out  1  one-cycle pulse in channel A RELEASE cycle
- done_b  out  1  one-cycle pulse in channel B RELEASE cycle
- busy_a  out  1  high in any channel A state other than IDLE
- busy_b  out  1  high in any channel B state other than IDLE

## Operation
- Channels A and B are identical and fully independent; both may be ACTIVE in the same cycle.
- Per-channel FSM: IDLE -> SETUP -> ACTIVE -> RELEASE -> IDLE.
- IDLE: if any req bit is high, pick the winner, register its index into sel, go to SETUP. Otherwise remain in IDLE.
- SETUP: sel is driven, Gn=1, one cycle, then ACTIVE.
- ACTIVE: Gn=0 and gnt = one-hot(sel) for exactly HOLD_CYCLES cycles. Hold counter is $clog2(HOLD_CYCLES+1) bits, loaded on SETUP->ACTIVE, decremented each ACTIVE cycle. Exit when the counter reaches 1.
- RELEASE: Gn=1, sel held unchanged, done=1 for one cycle, then IDLE.
- sel changes only on the IDLE->SETUP transition, never while Gn=0.
- Non-preemptive: a req change during SETUP/ACTIVE/RELEASE does not alter the current access. A dropped request still completes the access.
- Round-robin: a per-channel 2-bit pointer names the highest-priority index. After a grant to i, the pointer becomes (i+1) mod 4, wrapping 3->0. Reset value of the pointer is 0.
- A requester held continuously is re-granted only after every other pending requester on that channel has been served.

## Timing
- Reset values: sel_a=sel_b=0, g1n=g2n=1, gnt=0, done=0, busy=0, FSM=IDLE, pointer=0, counter=0.
- Reset asserted mid-access: on the next edge the outputs take reset values (Gn goes high immediately), with no RELEASE cycle and no done pulse.
- With req first high in IDLE at edge N: SETUP at N+1, Gn low from N+2 to N+1+HOLD_CYCLES, RELEASE at N+2+HOLD_CYCLES, IDLE at N+3+HOLD_CYCLES.
- Minimum spacing between accesses on one channel is HOLD_CYCLES+3 cycles.
- All outputs are registered; there is no combinational path from req to any output.

## Configuration
- LS139_FIXED_PRIORITY_EN defined: winner is always the lowest set req index. The pointer is neither updated nor used.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single request, HOLD_CYCLES=2: req_a=0100 held -> sel_a=2 from SETUP, g1n low for 2 cycles, gnt_a=0100 during those cycles, done_a pulse, then re-grant to requester 2 after IDLE.
- Contention: req_a=1111 held -> grant order 0,1,2,3,0. Between grants g1n=1 for 3 cycles (RELEASE, IDLE, SETUP).
- Pointer wrap: grant 3, then req_a=1001 -> next grant is 0; then req_a=1000 -> grant 3.
- Independence: req_a=0001 and req_b=1000 at the same edge -> g1n and g2n low in identical cycles, sel_a=0, sel_b=3.
- Reset mid-ACTIVE: rstn low for 1 cycle -> next edge g1n=1, gnt_a=0, sel_a=0, no done_a pulse. After reset, req_a=0010 produces a normal access with pointer restarted at 0.
- Request dropped in SETUP: access still lasts HOLD_CYCLES with done_a asserted. With LS139_FIXED_PRIORITY_EN defined and req_a=1111 held, every grant is 0.
